pll_vga_supervisor: RTL and testbench
=====================================

PLL_VGA_SUPERVISOR -- requirements
Module: pll_vga_supervisor

Interface
REQ-001: Parameter RST_PULSE_CYCLES, default 16, cycles pll_rst is held per PLL reset attempt.
REQ-002: Parameter LOCK_TIMEOUT_CYCLES, default 50000 (1 ms at 50 MHz), maximum wait for lock per attempt.
REQ-003: Parameter STABLE_CYCLES, default 1024, cycles the synchronized lock must stay high before downstream reset release.
REQ-004: Parameter MAX_RETRIES, default 4, failed lock attempts before entering FAULT.
REQ-005: refclk  in  1  single clock, the 50 MHz board reference that also feeds the VGA PLL; all logic on its rising edge.
REQ-006: rst  in  1  reset, synchronous, active-high.
REQ-007: pll_locked  in  1  PLL locked flag, asynchronous to refclk.
REQ-008: retry_req  in  1  single-cycle request to leave FAULT and restart the sequence.
REQ-009: pll_rst  out  1  reset to the VGA PLL, active-high.
REQ-010: vga_rst  out  1  reset request for pixel-domain logic, active-high; pixel domain resynchronizes it.
REQ-011: state  out  3  current FSM state encoding.
REQ-012: fault  out  1  high while in FAULT.
REQ-013: lock_loss_count  out  8  lock losses seen in RUNNING, saturating at 255.

Function
REQ-014: pll_locked SHALL pass through a 2-flop synchronizer; all decisions use the synchronized value lk, giving 2 cycles of input latency.
REQ-015: FSM states SHALL be PLL_RST, WAIT_LOCK, STABILIZE, RUNNING, FAULT, each with a fixed encoding from the package.
REQ-016: PLL_RST: pll_rst=1 for exactly RST_PULSE_CYCLES cycles, then go to WAIT_LOCK with the timeout counter cleared.
REQ-017: WAIT_LOCK: if lk=1, go to STABILIZE with the stable counter cleared; if the counter reaches LOCK_TIMEOUT_CYCLES-1 with lk=0, increment retry_cnt and go to PLL_RST, or go to FAULT when retry_cnt+1 = MAX_RETRIES.
REQ-018: STABILIZE: if lk=0, return to WAIT_LOCK with the timeout counter cleared and retry_cnt unchanged; if lk has stayed 1 for STABLE_CYCLES consecutive cycles, go to RUNNING and clear retry_cnt.
REQ-019: RUNNING: vga_rst=0; if lk=0, increment lock_loss_count (saturating) and go to PLL_RST in the same cycle.
REQ-020: FAULT: pll_rst=1, vga_rst=1, fault=1; on retry_req=1, clear retry_cnt and go to PLL_RST. The retry_req input SHALL be ignored in every other state.
REQ-021: vga_rst SHALL be 1 in every state except RUNNING; it deasserts on the cycle after the STABILIZE->RUNNING transition and reasserts on the cycle after lk falls.
REQ-022: All outputs SHALL be registered.
REQ-023: Counters SHALL be sized by $clog2 of their parameter and SHALL never wrap; the timeout and stable counters clear on every state entry.
REQ-024: If lk falls in the same cycle the stable count completes, the FSM SHALL go to WAIT_LOCK, because loss takes priority.

Reset
REQ-025: When rst=1, the FSM SHALL go to PLL_RST with all counters at 0 and synchronizer flops at 0. Outputs are pll_rst=1, vga_rst=1, fault=0, and lock_loss_count=0.
REQ-026: rst asserted mid-sequence, including in FAULT, SHALL restart from PLL_RST on the next cycle with no carried state.

Structure
REQ-027: Package pll_vga_supervisor_pkg SHALL hold the state enum typedef, the state width constant (3), and the counter width of lock_loss_count (8).
REQ-028: The synchronizer SHALL be the sub-module sync_2ff, also reusable by pixel-domain reset sync; the FSM and counters stay in pll_vga_supervisor.

Verification (parameters 4/20/8/2 for speed)
REQ-029: After rst, pll_locked rises at cycle 10 and stays high -> pll_rst is high for cycles 0-3, and vga_rst falls exactly 8 stable cycles plus 2 sync cycles after the rise.
REQ-030: pll_locked stays 0 -> two PLL_RST pulses of 4 cycles, each followed by a 20-cycle wait, then fault=1, pll_rst=1, and state=FAULT; then retry_req -> a new PLL_RST pulse.
REQ-031: pll_locked glitches high for 3 cycles in WAIT_LOCK -> enter STABILIZE, return to WAIT_LOCK, vga_rst never drops, retry_cnt unchanged.
REQ-032: In RUNNING, drop pll_locked 300 times -> lock_loss_count=255 with no wrap, and a PLL_RST pulse follows each drop.
REQ-033: rst during STABILIZE with lk=1 -> the next cycle shows state=PLL_RST, vga_rst=1, and lock_loss_count=0.

Source files
------------

// File: rtl/pll_vga_supervisor_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pll_vga_supervisor_pkg
// Purpose  : Shared types and constants for the VGA PLL supervisor: FSM state
//            encoding, state width, lock-loss counter width and a helper that
//            sizes the internal cycle counters.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package pll_vga_supervisor_pkg;

   localparam int STATE_W    = 3;
   localparam int LOSS_CNT_W = 8;

   typedef enum logic [STATE_W-1:0] {
      PLL_RST   = 3'd0,
      WAIT_LOCK = 3'd1,
      STABILIZE = 3'd2,
      RUNNING   = 3'd3,
      FAULT     = 3'd4
   } state_e;

   // Width needed to count 0 .. n-1; never less than one bit.
   function automatic int cnt_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage
`default_nettype wire

// File: rtl/sync_2ff.sv
`default_nettype none
// ============================================================================
// Module   : sync_2ff
// Purpose  : Two-flop synchronizer for level signals entering the clk domain.
//            Both stages clear on rst. Reusable for reset synchronization in
//            other clock domains.
// Ports    : clk  - destination clock
//            rst  - synchronous active-high reset
//            d    - asynchronous input
//            q    - synchronized output (2 cycles latency)
// Revision : 1.0 - initial release
// ============================================================================
module sync_2ff #(
   parameter int WIDTH = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   logic [WIDTH-1:0] meta_q;
   logic [WIDTH-1:0] sync_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         meta_q <= '0;
         sync_q <= '0;
      end else begin
         meta_q <= d;
         sync_q <= meta_q;
      end
   end

   assign q = sync_q;

endmodule
`default_nettype wire

// File: rtl/pll_vga_supervisor.sv
`default_nettype none
// ============================================================================
// Module   : pll_vga_supervisor
// Purpose  : Sequences reset of the VGA PLL, waits for lock with a timeout and
//            bounded retries, requires a stable lock before releasing the
//            pixel-domain reset, and counts lock losses while running.
// Ports    : refclk          - 50 MHz reference clock, all logic on rising edge
//            rst             - synchronous active-high reset
//            pll_locked      - PLL lock flag (asynchronous to refclk)
//            retry_req       - one-cycle request to leave FAULT
//            pll_rst         - reset to the VGA PLL (active-high)
//            vga_rst         - reset request for pixel-domain logic
//            state           - current FSM state encoding
//            fault           - high while in FAULT
//            lock_loss_count - saturating count of lock losses in RUNNING
// Revision : 1.0 - initial release
// ============================================================================
module pll_vga_supervisor
   import pll_vga_supervisor_pkg::*;
#(
   parameter int RST_PULSE_CYCLES    = 16,
   parameter int LOCK_TIMEOUT_CYCLES = 50000,
   parameter int STABLE_CYCLES       = 1024,
   parameter int MAX_RETRIES         = 4
) (
   input  logic                  refclk,
   input  logic                  rst,
   input  logic                  pll_locked,
   input  logic                  retry_req,
   output logic                  pll_rst,
   output logic                  vga_rst,
   output logic [STATE_W-1:0]    state,
   output logic                  fault,
   output logic [LOSS_CNT_W-1:0] lock_loss_count
);

   localparam int PULSE_W   = cnt_width(RST_PULSE_CYCLES);
   localparam int TIMEOUT_W = cnt_width(LOCK_TIMEOUT_CYCLES);
   localparam int STABLE_W  = cnt_width(STABLE_CYCLES);
   localparam int RETRY_W   = cnt_width(MAX_RETRIES);

   // Terminal values: each counter leaves its state on reaching these, so no
   // counter ever wraps.
   localparam logic [PULSE_W-1:0]   PULSE_LAST   = PULSE_W'(RST_PULSE_CYCLES - 1);
   localparam logic [TIMEOUT_W-1:0] TIMEOUT_LAST = TIMEOUT_W'(LOCK_TIMEOUT_CYCLES - 1);
   localparam logic [STABLE_W-1:0]  STABLE_LAST  = STABLE_W'(STABLE_CYCLES - 1);
   localparam logic [RETRY_W-1:0]   RETRY_LAST   = RETRY_W'(MAX_RETRIES - 1);

   // ------------------------------------------------------------------------
   // Lock synchronizer
   // ------------------------------------------------------------------------
   logic lk;

   sync_2ff #(
      .WIDTH (1)
   ) u_lock_sync (
      .clk (refclk),
      .rst (rst),
      .d   (pll_locked),
      .q   (lk)
   );

   // ------------------------------------------------------------------------
   // State and counters
   // ------------------------------------------------------------------------
   state_e                  state_q,       state_d;
   logic [PULSE_W-1:0]      pulse_cnt_q,   pulse_cnt_d;
   logic [TIMEOUT_W-1:0]    timeout_cnt_q, timeout_cnt_d;
   logic [STABLE_W-1:0]     stable_cnt_q,  stable_cnt_d;
   logic [RETRY_W-1:0]      retry_cnt_q,   retry_cnt_d;
   logic [LOSS_CNT_W-1:0]   loss_cnt_q,    loss_cnt_d;
   logic                    pll_rst_q,     pll_rst_d;
   logic                    vga_rst_q,     vga_rst_d;
   logic                    fault_q,       fault_d;

   always_ff @(posedge refclk) begin
      if (rst) begin
         state_q       <= PLL_RST;
         pulse_cnt_q   <= '0;
         timeout_cnt_q <= '0;
         stable_cnt_q  <= '0;
         retry_cnt_q   <= '0;
         loss_cnt_q    <= '0;
         pll_rst_q     <= 1'b1;
         vga_rst_q     <= 1'b1;
         fault_q       <= 1'b0;
      end else begin
         state_q       <= state_d;
         pulse_cnt_q   <= pulse_cnt_d;
         timeout_cnt_q <= timeout_cnt_d;
         stable_cnt_q  <= stable_cnt_d;
         retry_cnt_q   <= retry_cnt_d;
         loss_cnt_q    <= loss_cnt_d;
         pll_rst_q     <= pll_rst_d;
         vga_rst_q     <= vga_rst_d;
         fault_q       <= fault_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d     = state_q;
      retry_cnt_d = retry_cnt_q;
      loss_cnt_d  = loss_cnt_q;

      case (state_q)
         PLL_RST: begin
            if (pulse_cnt_q == PULSE_LAST) begin
               state_d = WAIT_LOCK;
            end
         end

         WAIT_LOCK: begin
            if (lk) begin
               state_d = STABILIZE;
            end else if (timeout_cnt_q == TIMEOUT_LAST) begin
               // Last permitted attempt failed: give up instead of retrying.
               if (retry_cnt_q == RETRY_LAST) begin
                  state_d = FAULT;
               end else begin
                  retry_cnt_d = retry_cnt_q + RETRY_W'(1);
                  state_d     = PLL_RST;
               end
            end
         end

         STABILIZE: begin
            // Loss of lock wins over a stable count completing this cycle.
            if (!lk) begin
               state_d = WAIT_LOCK;
            end else if (stable_cnt_q == STABLE_LAST) begin
               state_d     = RUNNING;
               retry_cnt_d = '0;
            end
         end

         RUNNING: begin
            if (!lk) begin
               state_d = PLL_RST;
               if (loss_cnt_q != {LOSS_CNT_W{1'b1}}) begin
                  loss_cnt_d = loss_cnt_q + LOSS_CNT_W'(1);
               end
            end
         end

         FAULT: begin
            if (retry_req) begin
               retry_cnt_d = '0;
               state_d     = PLL_RST;
            end
         end

         default: begin
            state_d = PLL_RST;
         end
      endcase
   end

   // Per-state cycle counters: they run only while the FSM stays in their
   // state, so every entry (including re-entry from another state) starts at 0.
   always_comb begin
      pulse_cnt_d   = '0;
      timeout_cnt_d = '0;
      stable_cnt_d  = '0;

      if ((state_q == PLL_RST) && (state_d == PLL_RST)) begin
         pulse_cnt_d = pulse_cnt_q + PULSE_W'(1);
      end
      if ((state_q == WAIT_LOCK) && (state_d == WAIT_LOCK)) begin
         timeout_cnt_d = timeout_cnt_q + TIMEOUT_W'(1);
      end
      if ((state_q == STABILIZE) && (state_d == STABILIZE)) begin
         stable_cnt_d = stable_cnt_q + STABLE_W'(1);
      end
   end

   // Outputs are decoded from the next state and registered, so they change
   // on the same edge as the state register and match it cycle for cycle.
   always_comb begin
      pll_rst_d = 1'b0;
      vga_rst_d = 1'b1;
      fault_d   = 1'b0;

      case (state_d)
         PLL_RST: pll_rst_d = 1'b1;
         RUNNING: vga_rst_d = 1'b0;
         FAULT: begin
            pll_rst_d = 1'b1;
            fault_d   = 1'b1;
         end
         default: begin
            pll_rst_d = 1'b0;
         end
      endcase
   end

   assign state           = state_q;
   assign pll_rst         = pll_rst_q;
   assign vga_rst         = vga_rst_q;
   assign fault           = fault_q;
   assign lock_loss_count = loss_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_pll_vga_supervisor.sv
`default_nettype none
// ============================================================================
// Module   : tb_pll_vga_supervisor
// Purpose  : Directed self-checking bench for pll_vga_supervisor with
//            parameters 4/20/8/2. Expected outputs are queued when stimulus is
//            driven and compared against the DUT a half cycle after each edge.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pll_vga_supervisor;
   import pll_vga_supervisor_pkg::*;

   localparam int RP = 4;
   localparam int LT = 20;
   localparam int SC = 8;
   localparam int MR = 2;

   logic       refclk = 1'b0;
   logic       rst;
   logic       pll_locked;
   logic       retry_req;
   logic       pll_rst;
   logic       vga_rst;
   logic [2:0] state;
   logic       fault;
   logic [7:0] lock_loss_count;

   int n_assert = 0;
   int n_fail   = 0;
   int lat;

   string       q_tag[$];
   logic [31:0] q_exp[$];

   always #5 refclk = ~refclk;

   pll_vga_supervisor #(
      .RST_PULSE_CYCLES    (RP),
      .LOCK_TIMEOUT_CYCLES (LT),
      .STABLE_CYCLES       (SC),
      .MAX_RETRIES         (MR)
   ) dut (
      .refclk          (refclk),
      .rst             (rst),
      .pll_locked      (pll_locked),
      .retry_req       (retry_req),
      .pll_rst         (pll_rst),
      .vga_rst         (vga_rst),
      .state           (state),
      .fault           (fault),
      .lock_loss_count (lock_loss_count)
   );

   // Advance one cycle; return at the falling edge (inputs and sampling).
   task automatic tick();
      @(posedge refclk);
      @(negedge refclk);
   endtask

   function automatic logic [31:0] pack(logic [2:0] st, logic pr, logic vr,
                                        logic f, logic [7:0] c);
      return {18'd0, st, pr, vr, f, c};
   endfunction

   // Output values that must be visible while the FSM sits in a given state.
   function automatic logic [31:0] exp_in(state_e st, logic [7:0] c);
      return pack(st, (st == PLL_RST) || (st == FAULT), st != RUNNING,
                  st == FAULT, c);
   endfunction

   function automatic logic [31:0] observe();
      return pack(state, pll_rst, vga_rst, fault, lock_loss_count);
   endfunction

   function automatic logic [7:0] sat(int k);
      return (k > 255) ? 8'd255 : 8'(k);
   endfunction

   // Lock rise sampled at edge 10: 2 sync cycles, one WAIT_LOCK decision
   // cycle already covered by sampling, then 8 STABILIZE cycles.
   function automatic state_e exp_a(int n);
      if (n <= 3)  return PLL_RST;
      if (n <= 11) return WAIT_LOCK;
      if (n <= 19) return STABILIZE;
      return RUNNING;
   endfunction

   // Glitch during first wait, two failed attempts, FAULT, retry, two more
   // failed attempts, FAULT again.
   function automatic state_e exp_b(int n);
      if (n <= 3)   return PLL_RST;
      if (n <= 7)   return WAIT_LOCK;
      if (n <= 10)  return STABILIZE;
      if (n <= 30)  return WAIT_LOCK;
      if (n <= 34)  return PLL_RST;
      if (n <= 54)  return WAIT_LOCK;
      if (n <= 59)  return FAULT;
      if (n <= 63)  return PLL_RST;
      if (n <= 83)  return WAIT_LOCK;
      if (n <= 87)  return PLL_RST;
      if (n <= 107) return WAIT_LOCK;
      return FAULT;
   endfunction

   task automatic sb_push(string tag, logic [31:0] e);
      q_tag.push_back(tag);
      q_exp.push_back(e);
   endtask

   task automatic sb_check(logic [31:0] obs);
      string       tag;
      logic [31:0] e;
      if (q_exp.size() == 0) begin
         tag = "sb_underflow";
         e   = 'x;
      end else begin
         tag = q_tag.pop_front();
         e   = q_exp.pop_front();
      end
      n_assert++;
      assert (obs === e) else begin
         n_fail++;
         $error("FAIL %s observed=0x%h expected=0x%h", tag, obs, e);
      end
   endtask

   initial begin
      rst        = 1'b1;
      pll_locked = 1'b0;
      retry_req  = 1'b0;
      repeat (3) tick();
      sb_push("reset", exp_in(PLL_RST, 8'd0));
      sb_check(observe());

      // Scenario A: clean lock-up; cycle 0 is the last reset edge.
      rst = 1'b0;
      for (int n = 0; n <= 24; n++) begin
         sb_push($sformatf("A_c%0d", n), exp_in(exp_a(n), 8'd0));
         sb_check(observe());
         pll_locked = (n >= 9);
         tick();
      end

      // Lock drops while running: each costs one count and a PLL reset pulse.
      for (int k = 1; k <= 300; k++) begin
         pll_locked = 1'b0;
         tick();
         pll_locked = 1'b1;
         tick();
         sb_push($sformatf("drop%0d_pre", k), exp_in(RUNNING, sat(k - 1)));
         sb_check(observe());
         tick();
         sb_push($sformatf("drop%0d_rst", k), exp_in(PLL_RST, sat(k)));
         sb_check(observe());
         lat = 0;
         while ((state !== RUNNING) && (lat < 40)) begin
            tick();
            lat++;
         end
         sb_push($sformatf("drop%0d_relock_lat", k), 32'd13);
         sb_check(32'(lat));
      end

      // Reset while stabilizing clears everything on the next cycle.
      pll_locked = 1'b0;
      tick();
      pll_locked = 1'b1;
      lat = 0;
      while ((state !== STABILIZE) && (lat < 40)) begin
         tick();
         lat++;
      end
      sb_push("in_stabilize", exp_in(STABILIZE, 8'd255));
      sb_check(observe());
      tick();
      rst = 1'b1;
      tick();
      sb_push("rst_in_stabilize", exp_in(PLL_RST, 8'd0));
      sb_check(observe());
      pll_locked = 1'b0;
      tick();

      // Scenario B: no lock apart from a 3-cycle glitch; retry_req pulses in
      // WAIT_LOCK and STABILIZE must be ignored; reset applied in FAULT.
      rst = 1'b0;
      for (int n = 0; n <= 112; n++) begin
         sb_push($sformatf("B_c%0d", n), exp_in(exp_b(n), 8'd0));
         sb_check(observe());
         pll_locked = (n >= 5) && (n <= 7);
         retry_req  = (n == 9) || (n == 20) || (n == 59);
         rst        = (n == 112);
         tick();
      end
      retry_req = 1'b0;
      sb_push("rst_in_fault", exp_in(PLL_RST, 8'd0));
      sb_check(observe());
      rst = 1'b0;
      tick();
      sb_push("after_fault_rst", exp_in(PLL_RST, 8'd0));
      sb_check(observe());

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_assert, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
